// File: rtl/gray_serial_ctrl.sv
// Handshaked serial Gray-to-binary converter: one result bit per clock, MSB first.
// Optional binary-to-Gray mode select is enabled by defining GRAY_SERIAL_B2G_EN.
module gray_serial_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef GRAY_SERIAL_B2G_EN
    input  logic             mode,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             busy,
    output logic [CNT_W-1:0] conv_cnt
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StHold
    } state_e;

    state_e             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_g, w_g_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH:0]     w_prev_ext;
`ifdef GRAY_SERIAL_B2G_EN
    logic               r_mode, w_mode_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_g     <= '0;
            r_b     <= '0;
            r_idx   <= IDX_TOP;
            r_cnt   <= '0;
`ifdef GRAY_SERIAL_B2G_EN
            r_mode  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef GRAY_SERIAL_B2G_EN
            r_mode  <= w_mode_nxt;
`endif
        end
    end

    // Bit idx+1 of the chain source; the extra top 0 bit seeds the MSB step.
    always_comb begin
`ifdef GRAY_SERIAL_B2G_EN
        w_prev_ext = r_mode ? {1'b0, r_g} : {1'b0, r_b};
`else
        w_prev_ext = {1'b0, r_b};
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
`ifdef GRAY_SERIAL_B2G_EN
        w_mode_nxt  = r_mode;
`endif
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_state_nxt = StConv;
                    w_g_nxt     = g_in;
                    w_b_nxt     = '0;
                    w_idx_nxt   = IDX_TOP;
`ifdef GRAY_SERIAL_B2G_EN
                    w_mode_nxt  = mode;
`endif
                end
            end
            StConv: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        w_b_nxt[i] = r_g[i] ^ w_prev_ext[i+1];
                    end
                end
                if (r_idx == '0) begin
                    w_state_nxt = StHold;
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StHold);
    assign busy      = (r_state != StIdle);
    assign b_out     = r_b;
    assign conv_cnt  = r_cnt;

endmodule

// File: tb/tb_gray_serial_ctrl.sv
// Directed, table-driven bench for gray_serial_ctrl (WIDTH=4, CNT_W=8).
// The mode test is built only when GRAY_SERIAL_B2G_EN is defined.
module tb_gray_serial_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] g_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] b_out;
    logic             busy;
    logic [CNT_W-1:0] conv_cnt;
`ifdef GRAY_SERIAL_B2G_EN
    logic             mode;
`endif

    int n_cmp;
    int n_err;
    logic [CNT_W-1:0] exp_cnt;

    typedef struct {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] b;
    } vec_t;

    vec_t vecs [16];

    gray_serial_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef GRAY_SERIAL_B2G_EN
        .mode      (mode),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_in      (g_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .busy      (busy),
        .conv_cnt  (conv_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with out_ready held high; checks latency, result and handshake.
    task automatic xfer(input logic [WIDTH-1:0] g, input logic md,
                        input logic [WIDTH-1:0] exp_b, input string name);
        int lat;
        int wt;
        wt = 0;
        while (!in_ready && wt < 20) begin
            step();
            wt++;
        end
        check({name, "_in_ready_wait"}, {31'd0, in_ready}, 32'd1);
`ifdef GRAY_SERIAL_B2G_EN
        mode = md;
`else
        if (md) $display("note: mode ignored in default build");
`endif
        in_valid  = 1'b1;
        g_in      = g;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        g_in     = ~g;
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, lat, WIDTH);
        check({name, "_b_out"}, {28'd0, b_out}, {28'd0, exp_b});
        step();
        exp_cnt = exp_cnt + CNT_W'(1);
        check({name, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
        check({name, "_cnt"}, {24'd0, conv_cnt}, {24'd0, exp_cnt});
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        g_in      = '0;
`ifdef GRAY_SERIAL_B2G_EN
        mode      = 1'b0;
`endif
        vecs[0]  = '{4'b0000, 4'b0000};
        vecs[1]  = '{4'b0001, 4'b0001};
        vecs[2]  = '{4'b0010, 4'b0011};
        vecs[3]  = '{4'b0011, 4'b0010};
        vecs[4]  = '{4'b0100, 4'b0111};
        vecs[5]  = '{4'b0101, 4'b0110};
        vecs[6]  = '{4'b0110, 4'b0100};
        vecs[7]  = '{4'b0111, 4'b0101};
        vecs[8]  = '{4'b1000, 4'b1111};
        vecs[9]  = '{4'b1001, 4'b1110};
        vecs[10] = '{4'b1010, 4'b1100};
        vecs[11] = '{4'b1011, 4'b1101};
        vecs[12] = '{4'b1100, 4'b1000};
        vecs[13] = '{4'b1101, 4'b1001};
        vecs[14] = '{4'b1110, 4'b1011};
        vecs[15] = '{4'b1111, 4'b1010};

        // Reset and idle state
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_b_out", {28'd0, b_out}, 32'd0);
        check("rst_cnt", {24'd0, conv_cnt}, 32'd0);

        // Single word, out_ready high
        xfer(4'b0110, 1'b0, 4'b0100, "single");

        // Back-to-back sweep
        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].g, 1'b0, vecs[i].b, $sformatf("sweep%0d", i));
        end
        check("sweep_cnt", {24'd0, conv_cnt}, 32'd17);

        // Backpressure: result held, new input ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        g_in      = 4'b0011;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) step();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            g_in     = 4'(i + 5);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_b_out", {28'd0, b_out}, 32'd2);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + CNT_W'(1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_cnt", {24'd0, conv_cnt}, {24'd0, exp_cnt});
        step();
        check("bp_one_xfer_busy", {31'd0, busy}, 32'd0);
        check("bp_one_xfer_cnt", {24'd0, conv_cnt}, {24'd0, exp_cnt});

        // Asynchronous reset in the second CONV cycle
        in_valid = 1'b1;
        g_in     = 4'b0110;
        step();
        in_valid = 1'b0;
        step();
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_b_out", {28'd0, b_out}, 32'd0);
        check("arst_cnt", {24'd0, conv_cnt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("arst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        rst_n   = 1'b1;
        exp_cnt = '0;
        step();
        xfer(4'b0001, 1'b0, 4'b0001, "post_rst");

        // Counter wrap
        for (int i = 0; i < 255; i++) begin
            xfer(vecs[i % 16].g, 1'b0, vecs[i % 16].b, "wrap");
        end
        check("wrap_cnt_zero", {24'd0, conv_cnt}, 32'd0);

`ifdef GRAY_SERIAL_B2G_EN
        xfer(4'b0100, 1'b1, 4'b0110, "b2g_0100");
        xfer(4'b1011, 1'b1, 4'b1110, "b2g_1011");
        xfer(4'b1000, 1'b0, 4'b1111, "g2b_after_b2g");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
